// File: rtl/debug_dump_pkg.sv
// rtl/debug_dump_pkg.sv - shared FSM encodings and constants for the register-dump sequencer
package debug_dump_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  function automatic int bytes_per_word(input int nb_data, input int nb_byte);
    return nb_data / nb_byte;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(32, 8);

  // ST_HDR/ST_HDR_WAIT are only reachable when DEBUG_DUMP_HEADER_EN is defined
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HDR_WAIT,
    ST_LOAD,
    ST_XFER,
    ST_DONE
  } dump_state_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SEND,
    SER_WAIT
  } ser_state_t;

endpackage

// File: rtl/debug_word_serializer.sv
// rtl/debug_word_serializer.sv - sends one register word MSB-first as UART bytes
import debug_dump_pkg::*;

module debug_word_serializer #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [NB_DATA-1:0] word,
  input  logic               tx_done,
  output logic [NB_BYTE-1:0] tx_data,
  output logic               tx_start,
  output logic               word_done
);

  localparam int BPW    = bytes_per_word(NB_DATA, NB_BYTE);
  localparam int NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(BPW - 1);

  ser_state_t          state_q, state_d;
  logic [NB_DATA-1:0]  shift_q;
  logic [NB_CNT-1:0]   byte_cnt_q;
  logic                ack;

  assign ack = (state_q == SER_WAIT) && tx_done;

  always_ff @(posedge clk) begin
    if (reset) state_q <= SER_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else if (load) begin
      shift_q    <= word;
      byte_cnt_q <= '0;
    end else if (ack && byte_cnt_q != LAST_BYTE) begin
      shift_q    <= shift_q << NB_BYTE;
      byte_cnt_q <= byte_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SER_IDLE: if (load) state_d = SER_SEND;
      SER_SEND: state_d = SER_WAIT;
      SER_WAIT: if (tx_done) state_d = (byte_cnt_q == LAST_BYTE) ? SER_IDLE : SER_SEND;
      default:  state_d = SER_IDLE;
    endcase
  end

  // word_done is combinational so the top can enter LOAD on the same edge as the last ack
  always_comb begin
    tx_start  = (state_q == SER_SEND);
    tx_data   = shift_q[NB_DATA-1 -: NB_BYTE];
    word_done = ack && (byte_cnt_q == LAST_BYTE);
  end

endmodule

// File: rtl/debug_reg_dump.sv
// rtl/debug_reg_dump.sv - streams every register over the UART on request
// DEBUG_DUMP_HEADER_EN prepends a single HEADER_BYTE to each dump.
import debug_dump_pkg::*;

module debug_reg_dump #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int SIZE_REG = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [NB_REG-1:0]  o_address_read_debug,
  input  logic [NB_DATA-1:0] i_data_read_debug,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [NB_REG-1:0] LAST_REG = NB_REG'(SIZE_REG - 1);

  dump_state_t         state_q, state_d;
  logic [NB_REG-1:0]   index_q, index_d;
  logic [NB_REG-1:0]   addr_q;
  logic                word_done;
  logic                ser_tx_start;
  logic [NB_BYTE-1:0]  ser_tx_data;

  debug_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .clk       (i_clk),
    .reset     (i_reset),
    .load      (state_q == ST_LOAD),
    .word      (i_data_read_debug),
    .tx_done   (i_tx_done),
    .tx_data   (ser_tx_data),
    .tx_start  (ser_tx_start),
    .word_done (word_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // The read address only moves on entry to LOAD, so it holds everywhere else
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      index_q <= '0;
      addr_q  <= '0;
    end else begin
      index_q <= index_d;
      if (state_d == ST_LOAD && state_q != ST_LOAD) addr_q <= index_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          index_d = '0;
`ifdef DEBUG_DUMP_HEADER_EN
          state_d = ST_HDR;
`else
          state_d = ST_LOAD;
`endif
        end
      end
`ifdef DEBUG_DUMP_HEADER_EN
      ST_HDR:      state_d = ST_HDR_WAIT;
      ST_HDR_WAIT: if (i_tx_done) state_d = ST_LOAD;
`endif
      ST_LOAD: state_d = ST_XFER;
      ST_XFER: begin
        if (word_done) begin
          if (index_q == LAST_REG) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy               = (state_q != ST_IDLE);
    o_done               = (state_q == ST_DONE);
    o_address_read_debug = addr_q;
    o_tx_start           = ser_tx_start;
    o_tx_data            = ser_tx_data;
`ifdef DEBUG_DUMP_HEADER_EN
    if (state_q == ST_HDR) o_tx_start = 1'b1;
    if (state_q == ST_HDR || state_q == ST_HDR_WAIT) o_tx_data = NB_BYTE'(HEADER_BYTE);
`endif
  end

endmodule

// File: doc/debug_reg_dump.md
# debug_reg_dump

Debug register-dump sequencer for the MIPS pipeline. It drives the register file's debug read port (read address out, read data in) and streams the contents of all `SIZE_REG` registers as bytes into the UART transmitter using a start/done handshake. The debug unit triggers it when the host requests a register snapshot. It is the consumer end of the decode stage's debug read interface.

## Interface
- `NB_DATA`, 32, register width in bits
- `NB_REG`, 5, register address width
- `SIZE_REG`, 32, number of registers dumped (≤ 2^NB_REG)
- `NB_BYTE`, 8, UART byte width
- `i_clk`  in  1  system clock, all logic on rising edge
- `i_reset`  in  1  reset, synchronous and active-high
- `i_start`  in  1  dump request, sampled only in IDLE
- `o_address_read_debug`  out  NB_REG  register-file debug read address
- `i_data_read_debug`  in  NB_DATA  register-file debug read data, combinational from the address
- `o_tx_data`  out  NB_BYTE  byte to UART TX
- `o_tx_start`  out  1  one-cycle pulse: UART latches `o_tx_data`
- `i_tx_done`  in  1  one-cycle pulse from UART TX: byte fully sent
- `o_busy`  out  1  high from leaving IDLE until return to IDLE
- `o_done`  out  1  one-cycle pulse when the last byte is acknowledged

## Operation
- FSM states: IDLE, HDR, HDR_WAIT, LOAD, SEND, WAIT, DONE. HDR and HDR_WAIT exist only with the macro (see Configuration).
- IDLE: `o_busy`=0. With `i_start`=1, clear index and byte count, then go to HDR (macro) or LOAD.
- LOAD: `o_address_read_debug`=index. On the edge, shift register ← `i_data_read_debug`, byte_cnt ← 0. Go to SEND.
- SEND: `o_tx_start`=1 for exactly this cycle. `o_tx_data` = shift[NB_DATA-1 -: 8], so bytes go MSB first. Go to WAIT.
- WAIT: hold `o_tx_data` stable until `i_tx_done`. On `i_tx_done`:
  - byte_cnt < NB_DATA/8-1: shift left 8, byte_cnt+1, go to SEND.
  - byte_cnt = NB_DATA/8-1 and index < SIZE_REG-1: index+1, go to LOAD.
  - byte_cnt = NB_DATA/8-1 and index = SIZE_REG-1: go to DONE.
- DONE: `o_done`=1 for one cycle, `o_busy`=1, then go to IDLE.
- Index never wraps. The dump ends at SIZE_REG-1.
- `i_start` outside IDLE is ignored and does not queue a second dump.
- `i_tx_done` outside WAIT/HDR_WAIT is ignored, including in the SEND cycle itself.
- `o_address_read_debug` holds its last value outside LOAD.
- Total bytes per dump: SIZE_REG·NB_DATA/8 (128 by default), +1 with the header.

## Timing
- Reset values: state IDLE, `o_address_read_debug`=0, `o_tx_data`=0, `o_tx_start`=0, `o_busy`=0, `o_done`=0, index=0, byte_cnt=0, shift=0.
- `i_reset` has priority over every other input. Reset mid-dump aborts on the next edge: no further `o_tx_start`, and no `o_done` for the aborted dump.
- `i_start` high at edge N (no macro): LOAD in cycle N+1, first `o_tx_start` in cycle N+2.
- `i_tx_done` at edge M in WAIT:
  - Next byte's `o_tx_start` in cycle M+1 (same word).
  - Or M+2 (new word, via LOAD).
- `o_done` in cycle M+1 after the final `i_tx_done`. `o_busy` falls in cycle M+2. A new `i_start` is accepted in IDLE from M+2.
- All outputs are registered or decoded from the state register only. No combinational path from inputs to outputs.

## Configuration
- `DEBUG_DUMP_HEADER_EN` defined:
  - IDLE → HDR on `i_start`.
  - HDR: `o_tx_start`=1, `o_tx_data`=`HEADER_BYTE` (0xA5).
  - HDR_WAIT: waits for `i_tx_done`, then goes to LOAD.
  - The first register byte's `o_tx_start` comes 2 cycles after the header's `i_tx_done`.
- Undefined: HDR/HDR_WAIT are not synthesized, and the dump starts directly with register 0.

## Structure
- Shared package `debug_dump_pkg`:
  - FSM state encoding.
  - `HEADER_BYTE` = 8'hA5.
  - `BYTES_PER_WORD` = NB_DATA/NB_BYTE.
- One natural sub-module: `debug_word_serializer`. It owns the shift register, byte_cnt and SEND/WAIT, and has a load strobe in and a word-done pulse out. The top owns index, LOAD/DONE and the header.

## Test plan
- No macro, reg k preloaded with 0x11223300+k, UART model answering `i_tx_done` 5 cycles after each `o_tx_start` → byte stream 11,22,33,00,11,22,33,01,…,11,22,33,1F. Exactly 128 `o_tx_start` pulses, then one `o_done`.
- `i_start` at cycle 10, `i_tx_done` at cycle 20 → `o_tx_start` at cycles 12 and 21. LOAD at 11 with address 0. `o_address_read_debug`=1 during the LOAD after the 4th done.
- `i_start` pulsed during a dump, and `i_tx_done` pulsed during SEND and IDLE → no extra bytes, no extra dump, stream unchanged.
- `i_reset` asserted after 50 bytes → next cycle: all outputs 0, `o_busy`=0, no `o_done`. A following `i_start` restarts at register 0 with byte 0x11.
- `DEBUG_DUMP_HEADER_EN` defined → first byte 0xA5, then the same 128 bytes. 129 `o_tx_start` pulses total.
- `i_tx_done` tied high in WAIT (back-to-back) → `o_tx_start` every 2 cycles within a word, 3 cycles across a word boundary. `o_done` 1 cycle after the last done.
